demux_buf: RTL and testbench
============================

# demux_buf

Buffered 1-to-NOUT demultiplexer: the dispatch-side counterpart of the mux family. It takes one valid/ready input stream and steers each word to the output port named by its select field. Each output has its own 2-entry FIFO, so a stalled consumer only blocks words destined for it. Words with an out-of-range select are dropped and counted. It sits wherever a shared producer (e.g. a response or writeback bus) fans out to several independent consumers.

## Interface
- WIDTH, 64, data width of every port
- NOUT, 4, number of output ports (2..16)
- SELW, $clog2(NOUT), select width (derived, do not override)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_valid  input  1  input word present
- in_ready  output  1  block can accept input this cycle
- in_data  input  WIDTH  input word
- in_sel  input  SELW  destination port index
- out_valid  output  NOUT  bit i: port i holds a word
- out_ready  input  NOUT  bit i: consumer i takes the word
- out_data  output  NOUT*WIDTH  port i data in bits [i*WIDTH +: WIDTH]
- drop  output  1  one-cycle pulse: a word was dropped
- err_count  output  8  saturating count of dropped words

## Operation
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Per port i: 2-entry FIFO with registered count cnt[i] (0..2), read/write pointers, head entry driven to out_data[i].
- out_valid[i] = (cnt[i] != 0). out_data[i] = head entry. Both come from registers with no combinational input path.
- in_ready = 1 if in_sel >= NOUT, else !(cnt[in_sel] == 2). It depends only on in_sel and registered counts. There is no combinational path from out_ready.
- Accept when in_valid && in_ready.
  - Legal sel: write in_data at the tail of FIFO[in_sel].
  - Illegal sel (in_sel >= NOUT, possible only when NOUT is not a power of 2): discard the word, pulse drop, and increment err_count.
- Pop port i when out_valid[i] && out_ready[i]. Head advances.
- Same-cycle push and pop on one port:
  - cnt = 1: cnt stays 1 and the new word becomes head next cycle.
  - cnt = 2: push cannot occur because in_ready = 0.
- Pops on different ports are independent. Any subset of ports may pop in the same cycle as one push.
- Ordering is preserved per port only. No ordering guarantee across ports.
- While out_valid[i] = 1 and out_ready[i] = 0, out_data[i] holds stable.
- err_count saturates at 255 and never wraps. It stays at 255 until reset.
- out_ready bits for empty ports are ignored.

## Timing
- Reset values: out_valid = 0, out_data = 0, cnt = 0, pointers = 0, drop = 0, err_count = 0. in_ready = 1 while reset is asserted and after it deasserts (all FIFOs empty).
- Reset asserted mid-operation clears all buffered words asynchronously; they are lost. No partial-state behaviour is defined.
- Latency: a word accepted at edge k is visible with out_valid at edge k (valid during cycle k+1), so latency is 1 cycle.
- Throughput: 1 word/cycle into any port whose consumer keeps out_ready high. A port absorbs 2 words of backpressure before in_ready drops for that destination.
- in_ready recovers one cycle after the pop that takes cnt from 2 to 1.
- drop asserts during the cycle after the dropping edge, for exactly one cycle per dropped word. err_count updates on the same edge.
- Head-of-line: if the current input targets a full port, in_ready = 0 and the input stalls. Other ports still drain. There is no reordering around a stalled input.

## Test plan
- Reset, then a single word: reset with in_valid = 0, then check all outputs are zero and in_ready = 1. Send in_data = 0xA5, sel = 2 at edge k. Required: out_valid = 4'b0100 after edge k and out_data[2] = 0xA5. Pop with out_ready[2] = 1; out_valid returns to 0.
- Fill and backpressure: out_ready = 0. Send 0x11, 0x22, 0x33 to sel 1. Required: first two words accepted. in_ready = 0 for the third while sel = 1, but in_ready = 1 if sel changes to 0. Pop once; the third word is accepted the next cycle. Drained order on port 1 is 0x11, 0x22, 0x33.
- Streaming with a concurrent pop at cnt = 1: all out_ready = 1. Send 100 words to sel 3, back to back. Required: no bubbles, in_ready constantly 1, words emerge in order with 1-cycle latency.
- Independent ports: port 0 is stalled and full. Interleave words to ports 1 to 3. Required: ports 1 to 3 drain normally. The input stalls only on cycles where sel = 0.
- Illegal select: with NOUT = 3, send sel = 3 three times. Required: each is accepted immediately, drop pulses three times, err_count = 3, and no out_valid. Then force 300 drops; err_count = 255.
- Reset mid-operation: with port 2 holding 2 words, assert reset asynchronously between edges. Required: out_valid = 0 and out_data = 0 immediately, without waiting for a clock edge. After release, in_ready = 1 and err_count = 0.

Source files
------------

// File: rtl/demux_buf_if.sv
// demux_buf_if
//   Groups the input stream, the per-port output streams and the drop
//   status of demux_buf into a single bundle.
//   slave  : view used by demux_buf itself
//   master : view used by the producer/consumers (or a testbench)
//   in_valid/in_ready/in_data/in_sel : single input stream with destination
//   out_valid/out_ready/out_data     : NOUT output streams, port i data in
//                                      out_data[i*WIDTH +: WIDTH]
//   drop/err_count                   : dropped-word pulse and saturating count
interface demux_buf_if #(
    parameter int WIDTH = 64,
    parameter int NOUT  = 4,
    parameter int SELW  = $clog2(NOUT)
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic [SELW-1:0]       in_sel;
    logic [NOUT-1:0]       out_valid;
    logic [NOUT-1:0]       out_ready;
    logic [NOUT*WIDTH-1:0] out_data;
    logic                  drop;
    logic [7:0]            err_count;

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, drop, err_count
    );

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, drop, err_count
    );
endinterface

// File: rtl/demux_buf.sv
// demux_buf
//   Buffered 1-to-NOUT demultiplexer. Each input word is steered to the
//   output port named by in_sel; every port has its own 2-entry FIFO so a
//   stalled consumer only blocks words destined for it. Words whose select
//   is out of range are discarded, flagged on drop and counted in err_count.
// Ports
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous, active-high; clears all buffered words and counters
//   bus   : demux_buf_if.slave (input stream, NOUT output streams, drop status)
module demux_buf #(
    parameter int WIDTH = 64,
    parameter int NOUT  = 4,
    parameter int SELW  = $clog2(NOUT)
) (
    input  logic        clk,
    input  logic        reset,
    demux_buf_if.slave  bus
);

    // Per-port FIFO state: two storage slots, 1-bit pointers, occupancy 0..2.
    logic [WIDTH-1:0] mem [NOUT][2];
    logic [1:0]       cnt [NOUT];
    logic [NOUT-1:0]  wptr;
    logic [NOUT-1:0]  rptr;

    logic [NOUT-1:0]  push;
    logic [NOUT-1:0]  pop;
    logic             sel_hit;
    logic             sel_full;
    logic             in_ready;
    logic             drop_q;
    logic [7:0]       err_q;

    logic [NOUT-1:0]       out_valid_w;
    logic [NOUT*WIDTH-1:0] out_data_w;

    // in_ready looks only at in_sel and the registered counts, never at
    // out_ready, so a pop frees space for the input one cycle later.
    // An out-of-range select matches no port, leaving sel_full low and the
    // word accepted immediately for discarding.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so
        // no path leaves it unassigned, which would infer a latch.
        sel_hit  = 1'b0;
        sel_full = 1'b0;
        push     = '0;
        pop      = '0;
        for (int i = 0; i < NOUT; i++) begin
            if (bus.in_sel == SELW'(i)) begin
                sel_hit  = 1'b1;
                sel_full = (cnt[i] == 2'd2);
            end
        end
        in_ready = !sel_full;
        for (int i = 0; i < NOUT; i++) begin
            push[i] = bus.in_valid && in_ready && (bus.in_sel == SELW'(i));
            // out_ready of an empty port is ignored.
            pop[i]  = (cnt[i] != 2'd0) && bus.out_ready[i];
        end
    end

    // Head entry of each FIFO drives its output slice straight from storage.
    always_comb begin
        out_valid_w = '0;
        out_data_w  = '0;
        for (int i = 0; i < NOUT; i++) begin
            out_valid_w[i]                 = (cnt[i] != 2'd0);
            out_data_w[i*WIDTH +: WIDTH]   = mem[i][rptr[i]];
        end
    end

    // NOTE: state registers are written with non-blocking assignments so all
    // of them sample pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the storage array is reset too, because out_data must
            // read as zero during and straight after reset.
            for (int i = 0; i < NOUT; i++) begin
                mem[i][0] <= '0;
                mem[i][1] <= '0;
                cnt[i]    <= 2'd0;
            end
            wptr   <= '0;
            rptr   <= '0;
            drop_q <= 1'b0;
            err_q  <= 8'd0;
        end else begin
            for (int i = 0; i < NOUT; i++) begin
                if (push[i]) begin
                    mem[i][wptr[i]] <= bus.in_data;
                    wptr[i]         <= ~wptr[i];
                end
                if (pop[i]) begin
                    rptr[i] <= ~rptr[i];
                end
                // Simultaneous push and pop leaves the count unchanged; the
                // pointers alone move the new word to the head.
                cnt[i] <= cnt[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            end
            drop_q <= bus.in_valid && !sel_hit;
            if (bus.in_valid && !sel_hit && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_data_w;
    assign bus.drop      = drop_q;
    assign bus.err_count = err_q;

endmodule

// File: tb/tb_demux_buf.sv
// tb_demux_buf
//   Directed bench for demux_buf. Two instances share clk/reset: a 4-port
//   build for FIFO behaviour and a 3-port build for out-of-range selects.
module tb_demux_buf;

    localparam int W = 64;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    demux_buf_if #(.WIDTH(W), .NOUT(4)) bus4 ();
    demux_buf_if #(.WIDTH(W), .NOUT(3)) bus3 ();

    demux_buf #(.WIDTH(W), .NOUT(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    demux_buf #(.WIDTH(W), .NOUT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Return 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] port4(input int p);
        return bus4.out_data[p*W +: W];
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.in_data   = '0;
        bus4.in_sel    = '0;
        bus4.out_ready = '0;
        bus3.in_valid  = 1'b0;
        bus3.in_data   = '0;
        bus3.in_sel    = '0;
        bus3.out_ready = '0;

        // ---------------- reset state ----------------
        #12;
        check("rst_in_ready", 64'(bus4.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus4.out_valid), 64'd0);
        check("rst_out_data_zero", 64'(|bus4.out_data), 64'd0);
        check("rst_err_count", 64'(bus3.err_count), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", 64'(bus4.in_ready), 64'd1);
        check("post_rst_drop", 64'(bus4.drop), 64'd0);

        // ---------------- single word ----------------
        bus4.in_valid = 1'b1;
        bus4.in_data  = 64'hA5;
        bus4.in_sel   = 2'd2;
        #1;
        check("single_in_ready", 64'(bus4.in_ready), 64'd1);
        tick();
        bus4.in_valid = 1'b0;
        check("single_out_valid", 64'(bus4.out_valid), 64'b0100);
        check("single_out_data", port4(2), 64'hA5);
        bus4.out_ready = 4'b0100;
        tick();
        bus4.out_ready = 4'b0000;
        check("single_popped", 64'(bus4.out_valid), 64'd0);

        // ---------------- fill and backpressure ----------------
        bus4.in_valid = 1'b1;
        bus4.in_sel   = 2'd1;
        bus4.in_data  = 64'h11;
        tick();
        bus4.in_data  = 64'h22;
        tick();
        bus4.in_data  = 64'h33;
        #1;
        check("full_in_ready_sel1", 64'(bus4.in_ready), 64'd0);
        bus4.in_sel = 2'd0;
        bus4.in_valid = 1'b0;
        #1;
        check("full_in_ready_sel0", 64'(bus4.in_ready), 64'd1);
        bus4.in_sel   = 2'd1;
        bus4.in_valid = 1'b1;
        check("full_head", port4(1), 64'h11);
        bus4.out_ready = 4'b0010;
        tick();
        // Pop of 0x11 only; 0x33 is still waiting.
        bus4.out_ready = 4'b0000;
        check("recover_in_ready", 64'(bus4.in_ready), 64'd1);
        check("recover_head", port4(1), 64'h22);
        tick();
        bus4.in_valid = 1'b0;
        check("third_accepted_full", 64'(bus4.in_ready), 64'd0);
        bus4.out_ready = 4'b0010;
        check("drain_22", port4(1), 64'h22);
        tick();
        check("drain_33", port4(1), 64'h33);
        tick();
        bus4.out_ready = 4'b0000;
        check("drain_empty", 64'(bus4.out_valid), 64'd0);

        // ---------------- streaming 100 words to port 3 ----------------
        bus4.out_ready = 4'b1000;
        bus4.in_sel    = 2'd3;
        bus4.in_valid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus4.in_data = 64'h1000 + 64'(i);
            #1;
            check("stream_in_ready", 64'(bus4.in_ready), 64'd1);
            tick();
            check("stream_data", port4(3), 64'h1000 + 64'(i));
            check("stream_valid", 64'(bus4.out_valid), 64'b1000);
        end
        bus4.in_valid = 1'b0;
        tick();
        check("stream_end_empty", 64'(bus4.out_valid), 64'd0);
        bus4.out_ready = 4'b0000;

        // ---------------- independent ports ----------------
        bus4.in_valid = 1'b1;
        bus4.in_sel   = 2'd0;
        bus4.in_data  = 64'hA0;
        tick();
        bus4.in_data  = 64'hA1;
        tick();
        bus4.out_ready = 4'b1110;
        bus4.in_sel    = 2'd1;
        bus4.in_data   = 64'hB1;
        #1;
        check("ind_ready_p1", 64'(bus4.in_ready), 64'd1);
        tick();
        check("ind_p1_data", port4(1), 64'hB1);
        bus4.in_sel  = 2'd0;
        bus4.in_data = 64'hC0;
        #1;
        check("ind_stall_p0", 64'(bus4.in_ready), 64'd0);
        tick();
        check("ind_p0_stable", port4(0), 64'hA0);
        check("ind_valid_after_stall", 64'(bus4.out_valid), 64'b0001);
        bus4.in_sel  = 2'd2;
        bus4.in_data = 64'hB2;
        #1;
        check("ind_ready_p2", 64'(bus4.in_ready), 64'd1);
        tick();
        check("ind_p2_data", port4(2), 64'hB2);
        bus4.in_sel  = 2'd3;
        bus4.in_data = 64'hB3;
        tick();
        check("ind_p3_data", port4(3), 64'hB3);
        check("ind_valid_p0_p3", 64'(bus4.out_valid), 64'b1001);
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 4'b1111;
        tick();
        check("ind_p0_second", port4(0), 64'hA1);
        tick();
        bus4.out_ready = 4'b0000;
        check("ind_all_empty", 64'(bus4.out_valid), 64'd0);

        // ---------------- illegal select on 3-port build ----------------
        bus3.in_valid = 1'b1;
        bus3.in_sel   = 2'd3;
        bus3.in_data  = 64'hDEAD;
        #1;
        check("ill_in_ready", 64'(bus3.in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ill_drop", 64'(bus3.drop), 64'd1);
        end
        check("ill_err_count3", 64'(bus3.err_count), 64'd3);
        check("ill_no_valid", 64'(bus3.out_valid), 64'd0);
        bus3.in_valid = 1'b0;
        tick();
        check("ill_drop_low", 64'(bus3.drop), 64'd0);
        check("ill_err_hold", 64'(bus3.err_count), 64'd3);
        bus3.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        bus3.in_valid = 1'b0;
        tick();
        check("ill_err_sat", 64'(bus3.err_count), 64'd255);
        check("ill_no_valid_sat", 64'(bus3.out_valid), 64'd0);

        // ---------------- reset mid-operation ----------------
        bus4.in_valid = 1'b1;
        bus4.in_sel   = 2'd2;
        bus4.in_data  = 64'hD0;
        tick();
        bus4.in_data  = 64'hD1;
        tick();
        bus4.in_valid = 1'b0;
        check("mid_valid_before", 64'(bus4.out_valid), 64'b0100);
        check("mid_full_ready", 64'(bus4.in_ready), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_async_valid", 64'(bus4.out_valid), 64'd0);
        check("mid_async_data", 64'(|bus4.out_data), 64'd0);
        check("mid_async_ready", 64'(bus4.in_ready), 64'd1);
        check("mid_async_err", 64'(bus3.err_count), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        check("mid_release_ready", 64'(bus4.in_ready), 64'd1);
        check("mid_release_err", 64'(bus3.err_count), 64'd0);
        check("mid_release_valid", 64'(bus4.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
